mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory bus between the IF-stage instruction fetch and the MEM-stage load/store.
- Issues one bus transaction at a time and holds completed results until the pipeline advances.
- Produces stall requests `stallreq_if` and `stallreq_mem` for the pipeline stall controller.
- Sits between the pipeline stages and the external SRAM-style bus, which uses a req/ack handshake.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-select width is DATA_W/8

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- inst_req  in  1  IF wants a fetch; held stable while stallreq_if=1
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetched word
- stallreq_if  out  1  fetch not yet complete
- data_req  in  1  MEM wants a load/store; held stable while stallreq_mem=1
- data_we  in  1  1=store
- data_sel  in  DATA_W/8  byte enables
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data
- stallreq_mem  out  1  data access not yet complete
- pipe_hold  in  1  OR of all other stall sources (e.g. EX multi-cycle); must not depend on this block's outputs
- flush  in  1  pipeline flush/exception; kills the fetch
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_sel  out  DATA_W/8  bus byte enables
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_ack  in  1  one-cycle completion pulse
- bus_rdata  in  DATA_W  read data, valid with bus_ack

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- Registered flags:
  - i_done, d_done: result held.
  - i_kill: in-flight fetch must be discarded.
- Holding registers: i_buf, d_buf.
- Reset values:
  - State: IDLE.
  - Flags: 0.
  - Buffers: 0.
  - bus_req, bus_we, bus_sel, bus_addr, bus_wdata: all 0.
  - stallreq_if, stallreq_mem: 0 while rst=1.
- IDLE transitions:
  - If data_req && !d_done, go to BUSY_D; data has priority as the older instruction.
  - Else if inst_req && !i_done && !flush, go to BUSY_I.
  - bus_* outputs are registered and are driven from the next cycle.
  - A request costs a minimum of 2 cycles (issue + ack).
- BUSY_x: bus_req=1 and address/controls held constant until bus_ack. A transaction is never aborted.
- On bus_ack in BUSY_D:
  - d_buf<=bus_rdata; d_done<=1.
  - Return to IDLE; bus_req drops the next cycle.
- On bus_ack in BUSY_I:
  - If !i_kill && !flush: i_buf<=bus_rdata; i_done<=1.
  - In all cases: i_kill<=0 and return to IDLE.
- Stall outputs (combinational):
  - done_i_now = i_done | (BUSY_I & bus_ack & !i_kill & !flush)
  - stallreq_if = inst_req & !done_i_now & !flush
  - stallreq_mem is the same form using data terms; flush does not apply to data.
- Read data outputs: inst_rdata/data_rdata = bus_rdata in the ack cycle, otherwise the buffer.
- Advance condition: stallreq_if=0 && stallreq_mem=0 && pipe_hold=0. On advance, i_done<=0 and d_done<=0.
- Flush:
  - Clears i_done.
  - If in BUSY_I, sets i_kill.
  - Does not cancel BUSY_D; a store already issued completes.
  - d_done is cleared by the advance condition.
- Both requests at once: data first, then fetch. The completed data result is held in d_done/d_buf so it is not re-issued while the fetch is still stalled.
- Reset mid-transaction: the FSM returns to IDLE at once, regardless of any outstanding bus ack. A late bus_ack after reset is ignored in IDLE.
- Widths: bus_sel = data_sel. Inst fetches use an all-ones sel with we=0.

Decomposition:
- Shared package/macro file holds:
  - FSM state encodings: ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D.
  - The STOP/NOSTOP and RSTENABLE constants already used by the stall controller.
- No sub-module is needed. Optionally factor a `result_hold` register slice (done flag + buffer + advance clear) and instantiate it twice.

Test Plan:
- Fetch only: inst_req=1, addr 0x0000_1000, bus_ack 3 cycles after bus_req with rdata 0x2402_0005 → stallreq_if=1 until the ack cycle, inst_rdata=0x2402_0005 in the ack cycle, bus_req low the next cycle.
- Simultaneous: data load 0x8000_0040 and fetch 0x1004 together → data transaction first with rdata 0xDEAD_BEEF held in data_rdata, then fetch. stallreq_mem drops at the data ack; stallreq_if drops at the fetch ack. Exactly 2 bus transactions occur.
- Store: data_we=1, sel=4'b0011, wdata=0x0000_ABCD → bus_we=1, bus_sel=0011, bus_wdata=0x0000_ABCD held until ack; stallreq_mem=0 in the ack cycle.
- Flush during fetch: flush pulses while in BUSY_I → bus_req stays asserted until ack, no i_done is set, inst_rdata is not captured, and a new fetch issues after IDLE.
- pipe_hold=1 after both transactions complete → no re-issue, both stallreqs stay 0, buffers stay stable; when pipe_hold falls, flags clear and the next requests issue.
- Reset in BUSY_D → next cycle state is IDLE, bus_req=0, stallreqs follow the reset rule; a stray bus_ack afterwards has no effect.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/MEM memory-port arbiter and the stall controller.
package mem_port_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE   = 2'd0;
   localparam logic [1:0] ARB_BUSY_I = 2'd1;
   localparam logic [1:0] ARB_BUSY_D = 2'd2;

   localparam logic STOP      = 1'b1;
   localparam logic NOSTOP    = 1'b0;
   localparam logic RSTENABLE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_result_hold.sv
// Done flag plus result buffer; capture sets the flag, clear (pipeline advance) wins over capture.
module mem_port_arbiter_result_hold
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              clear,
   input  logic [DATA_W-1:0] din,
   output logic              done,
   output logic [DATA_W-1:0] dout
);

   logic              done_q, done_d;
   logic [DATA_W-1:0] buf_q, buf_d;

   always_comb begin
      done_d = done_q;
      buf_d  = buf_q;
      if (capture) begin
         done_d = 1'b1;
         buf_d  = din;
      end
      if (clear) begin
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RSTENABLE) begin
         done_q <= 1'b0;
         buf_q  <= '0;
      end else begin
         done_q <= done_d;
         buf_q  <= buf_d;
      end
   end

   assign done = done_q;
   assign dout = buf_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory bus between IF fetch and MEM load/store; one transaction at a time.
//
// state      | meaning
// ARB_IDLE   | no transaction outstanding; pick data first, then fetch
// ARB_BUSY_I | fetch on the bus, waiting for bus_ack
// ARB_BUSY_D | load/store on the bus, waiting for bus_ack
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic [DATA_W-1:0]   inst_rdata,
   output logic                stallreq_if,
   input  logic                data_req,
   input  logic                data_we,
   input  logic [DATA_W/8-1:0] data_sel,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                stallreq_mem,
   input  logic                pipe_hold,
   input  logic                flush,
   output logic                bus_req,
   output logic                bus_we,
   output logic [DATA_W/8-1:0] bus_sel,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_ack,
   input  logic [DATA_W-1:0]   bus_rdata
);

   localparam int SEL_W = DATA_W / 8;

   logic [1:0]        state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
   logic              i_kill_q, i_kill_d;

   logic              rst_act;
   logic              ack_i, ack_d, i_cap;
   logic              i_done, d_done;
   logic [DATA_W-1:0] i_buf, d_buf;
   logic              done_i_now, done_d_now;
   logic              stall_if, stall_mem, advance;

   assign rst_act = (rst == RSTENABLE);
   assign ack_i   = (state_q == ARB_BUSY_I) && bus_ack;
   assign ack_d   = (state_q == ARB_BUSY_D) && bus_ack;
   // A fetch that was flushed, now or earlier, must never land in i_buf.
   assign i_cap   = ack_i && !i_kill_q && !flush;

   assign done_i_now = i_done || i_cap;
   assign done_d_now = d_done || ack_d;
   assign stall_if   = !rst_act && inst_req && !done_i_now && !flush;
   assign stall_mem  = !rst_act && data_req && !done_d_now;
   assign advance    = !stall_if && !stall_mem && !pipe_hold;

   mem_port_arbiter_result_hold #(.DATA_W(DATA_W)) u_i_hold (
      .clk     (clk),
      .rst     (rst),
      .capture (i_cap),
      .clear   (advance || flush),
      .din     (bus_rdata),
      .done    (i_done),
      .dout    (i_buf)
   );

   mem_port_arbiter_result_hold #(.DATA_W(DATA_W)) u_d_hold (
      .clk     (clk),
      .rst     (rst),
      .capture (ack_d),
      .clear   (advance),
      .din     (bus_rdata),
      .done    (d_done),
      .dout    (d_buf)
   );

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      i_kill_d    = i_kill_q;
      case (state_q)
         ARB_IDLE: begin
            if (data_req && !d_done) begin
               state_d     = ARB_BUSY_D;
               bus_req_d   = 1'b1;
               bus_we_d    = data_we;
               bus_sel_d   = data_sel;
               bus_addr_d  = data_addr;
               bus_wdata_d = data_wdata;
            end else if (inst_req && !i_done && !flush) begin
               state_d     = ARB_BUSY_I;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_sel_d   = '1;
               bus_addr_d  = inst_addr;
               bus_wdata_d = '0;
            end
         end
         ARB_BUSY_I: begin
            if (bus_ack) begin
               state_d     = ARB_IDLE;
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_sel_d   = '0;
               bus_addr_d  = '0;
               bus_wdata_d = '0;
               i_kill_d    = 1'b0;
            end else if (flush) begin
               i_kill_d = 1'b1;
            end
         end
         ARB_BUSY_D: begin
            if (bus_ack) begin
               state_d     = ARB_IDLE;
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_sel_d   = '0;
               bus_addr_d  = '0;
               bus_wdata_d = '0;
            end
         end
         default: begin
            state_d   = ARB_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_act) begin
         state_q     <= ARB_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         i_kill_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         i_kill_q    <= i_kill_d;
      end
   end

   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_sel      = bus_sel_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign stallreq_if  = stall_if ? STOP : NOSTOP;
   assign stallreq_mem = stall_mem ? STOP : NOSTOP;
   assign inst_rdata   = ack_i ? bus_rdata : i_buf;
   assign data_rdata   = ack_d ? bus_rdata : d_buf;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-timed bus acks, hand-computed expected values.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        stallreq_if;
   logic        data_req;
   logic        data_we;
   logic [3:0]  data_sel;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        stallreq_mem;
   logic        pipe_hold;
   logic        flush;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int total = 0;
   int bad   = 0;
   int xact_cnt = 0;
   int xact_base;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_rdata   (inst_rdata),
      .stallreq_if  (stallreq_if),
      .data_req     (data_req),
      .data_we      (data_we),
      .data_sel     (data_sel),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_rdata   (data_rdata),
      .stallreq_mem (stallreq_mem),
      .pipe_hold    (pipe_hold),
      .flush        (flush),
      .bus_req      (bus_req),
      .bus_we       (bus_we),
      .bus_sel      (bus_sel),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_ack      (bus_ack),
      .bus_rdata    (bus_rdata)
   );

   always @(posedge clk) begin
      if (bus_req && bus_ack) xact_cnt <= xact_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven there.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; inst_req = 1'b1; inst_addr = 32'h0; data_req = 1'b1; data_we = 1'b0;
      data_sel = 4'hF; data_addr = 32'h0; data_wdata = 32'h0; pipe_hold = 1'b0;
      flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;

      // reset: stalls suppressed, bus idle
      step(); settle();
      chk("rst_stall_if", {31'b0, stallreq_if}, 32'd0);
      chk("rst_stall_mem", {31'b0, stallreq_mem}, 32'd0);
      chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      step(); data_req = 1'b0; inst_req = 1'b0;

      // fetch only, ack 3 cycles after bus_req
      step(); rst = 1'b0; inst_req = 1'b1; inst_addr = 32'h0000_1000; settle();
      chk("f_stall_c0", {31'b0, stallreq_if}, 32'd1);
      step(); settle();
      chk("f_bus_req", {31'b0, bus_req}, 32'd1);
      chk("f_bus_addr", bus_addr, 32'h0000_1000);
      chk("f_bus_sel", {28'b0, bus_sel}, 32'hF);
      chk("f_bus_we", {31'b0, bus_we}, 32'd0);
      step(); settle();
      chk("f_stall_c2", {31'b0, stallreq_if}, 32'd1);
      step(); settle();
      chk("f_stall_c3", {31'b0, stallreq_if}, 32'd1);
      step(); bus_ack = 1'b1; bus_rdata = 32'h2402_0005; settle();
      chk("f_stall_ack", {31'b0, stallreq_if}, 32'd0);
      chk("f_rdata_ack", inst_rdata, 32'h2402_0005);
      step(); bus_ack = 1'b0; bus_rdata = 32'h0; inst_req = 1'b0; settle();
      chk("f_bus_req_drop", {31'b0, bus_req}, 32'd0);
      chk("f_rdata_held", inst_rdata, 32'h2402_0005);

      // simultaneous load + fetch: data first
      xact_base = xact_cnt;
      step(); data_req = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_addr = 32'h8000_0040;
      inst_req = 1'b1; inst_addr = 32'h0000_1004; settle();
      chk("s_stall_mem", {31'b0, stallreq_mem}, 32'd1);
      chk("s_stall_if", {31'b0, stallreq_if}, 32'd1);
      step(); settle();
      chk("s_d_addr", bus_addr, 32'h8000_0040);
      chk("s_d_we", {31'b0, bus_we}, 32'd0);
      step(); bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; settle();
      chk("s_mem_drop", {31'b0, stallreq_mem}, 32'd0);
      chk("s_d_rdata_ack", data_rdata, 32'hDEAD_BEEF);
      chk("s_if_still", {31'b0, stallreq_if}, 32'd1);
      step(); bus_ack = 1'b0; bus_rdata = 32'h0; settle();
      chk("s_idle_req", {31'b0, bus_req}, 32'd0);
      chk("s_mem_held", {31'b0, stallreq_mem}, 32'd0);
      chk("s_d_rdata_held", data_rdata, 32'hDEAD_BEEF);
      step(); settle();
      chk("s_i_req", {31'b0, bus_req}, 32'd1);
      chk("s_i_addr", bus_addr, 32'h0000_1004);
      step(); bus_ack = 1'b1; bus_rdata = 32'h8C43_0000; settle();
      chk("s_if_drop", {31'b0, stallreq_if}, 32'd0);
      chk("s_i_rdata", inst_rdata, 32'h8C43_0000);
      chk("s_mem_ack", {31'b0, stallreq_mem}, 32'd0);
      step(); bus_ack = 1'b0; bus_rdata = 32'h0; data_req = 1'b0; inst_req = 1'b0; settle();
      chk("s_end_req", {31'b0, bus_req}, 32'd0);
      chk("s_xacts", xact_cnt - xact_base, 32'd2);

      // store with partial byte enables
      step(); data_req = 1'b1; data_we = 1'b1; data_sel = 4'b0011; data_addr = 32'h8000_0044;
      data_wdata = 32'h0000_ABCD; settle();
      chk("st_stall", {31'b0, stallreq_mem}, 32'd1);
      step(); settle();
      chk("st_req", {31'b0, bus_req}, 32'd1);
      chk("st_we", {31'b0, bus_we}, 32'd1);
      chk("st_sel", {28'b0, bus_sel}, 32'h3);
      chk("st_wdata", bus_wdata, 32'h0000_ABCD);
      step(); settle();
      chk("st_wdata_hold", bus_wdata, 32'h0000_ABCD);
      chk("st_addr_hold", bus_addr, 32'h8000_0044);
      step(); bus_ack = 1'b1; settle();
      chk("st_stall_ack", {31'b0, stallreq_mem}, 32'd0);
      step(); bus_ack = 1'b0; data_req = 1'b0; data_we = 1'b0; data_sel = 4'hF; settle();
      chk("st_req_drop", {31'b0, bus_req}, 32'd0);

      // flush during fetch: transaction completes but result discarded
      step(); inst_req = 1'b1; inst_addr = 32'h0000_2000;
      step(); flush = 1'b1; settle();
      chk("fl_stall_flush", {31'b0, stallreq_if}, 32'd0);
      step(); flush = 1'b0; inst_addr = 32'h0000_3000; settle();
      chk("fl_req_held", {31'b0, bus_req}, 32'd1);
      chk("fl_addr_held", bus_addr, 32'h0000_2000);
      chk("fl_stall_if", {31'b0, stallreq_if}, 32'd1);
      step(); bus_ack = 1'b1; bus_rdata = 32'h1111_1111; settle();
      chk("fl_stall_killed", {31'b0, stallreq_if}, 32'd1);
      step(); bus_ack = 1'b0; bus_rdata = 32'h0; settle();
      chk("fl_no_capture", inst_rdata, 32'h8C43_0000);
      chk("fl_idle_req", {31'b0, bus_req}, 32'd0);
      chk("fl_no_done", {31'b0, stallreq_if}, 32'd1);
      step(); settle();
      chk("fl_reissue", {31'b0, bus_req}, 32'd1);
      chk("fl_new_addr", bus_addr, 32'h0000_3000);
      step(); bus_ack = 1'b1; bus_rdata = 32'h2222_2222; settle();
      chk("fl_new_stall", {31'b0, stallreq_if}, 32'd0);
      chk("fl_new_rdata", inst_rdata, 32'h2222_2222);
      step(); bus_ack = 1'b0; bus_rdata = 32'h0; inst_req = 1'b0;

      // pipe_hold after both complete: no re-issue, results held
      step(); data_req = 1'b1; data_addr = 32'h8000_0048; inst_req = 1'b1;
      inst_addr = 32'h0000_4000; pipe_hold = 1'b1;
      step();
      step(); bus_ack = 1'b1; bus_rdata = 32'hAAAA_5555;
      step(); bus_ack = 1'b0; bus_rdata = 32'h0;
      step(); settle();
      chk("ph_fetch_addr", bus_addr, 32'h0000_4000);
      step(); bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      xact_base = xact_cnt;
      step(); bus_ack = 1'b0; bus_rdata = 32'h0; settle();
      chk("ph_stall_if", {31'b0, stallreq_if}, 32'd0);
      chk("ph_stall_mem", {31'b0, stallreq_mem}, 32'd0);
      chk("ph_req_idle", {31'b0, bus_req}, 32'd0);
      chk("ph_d_buf", data_rdata, 32'hAAAA_5555);
      chk("ph_i_buf", inst_rdata, 32'h1234_5678);
      step(); settle();
      chk("ph_no_reissue", {31'b0, bus_req}, 32'd0);
      chk("ph_d_buf2", data_rdata, 32'hAAAA_5555);
      step(); pipe_hold = 1'b0; settle();
      chk("ph_adv_stall", {31'b0, stallreq_mem}, 32'd0);
      step(); data_addr = 32'h8000_004C; inst_addr = 32'h0000_4004; settle();
      chk("ph_new_stall_mem", {31'b0, stallreq_mem}, 32'd1);
      chk("ph_new_stall_if", {31'b0, stallreq_if}, 32'd1);
      chk("ph_xacts_held", xact_cnt - xact_base, 32'd1);
      step(); settle();
      chk("ph_new_req", {31'b0, bus_req}, 32'd1);
      chk("ph_new_addr", bus_addr, 32'h8000_004C);

      // reset while in BUSY_D, then a stray ack
      step(); rst = 1'b1; settle();
      chk("r_stall_mem", {31'b0, stallreq_mem}, 32'd0);
      chk("r_stall_if", {31'b0, stallreq_if}, 32'd0);
      step(); rst = 1'b0; data_req = 1'b0; inst_req = 1'b0; bus_ack = 1'b1;
      bus_rdata = 32'h5A5A_5A5A; settle();
      chk("r_req", {31'b0, bus_req}, 32'd0);
      chk("r_stray_d", data_rdata, 32'h0);
      step(); bus_ack = 1'b0; bus_rdata = 32'h0; settle();
      chk("r_req2", {31'b0, bus_req}, 32'd0);
      chk("r_d_buf", data_rdata, 32'h0);
      chk("r_i_buf", inst_rdata, 32'h0);
      chk("r_stall_mem2", {31'b0, stallreq_mem}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
